// File: rtl/tristate_bus_sched.sv
// tristate_bus_sched: round-robin owner scheduler for a shared tri-state net with all-off turnaround gaps
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   req[N]          : level requests, held while the net is wanted
//   grant[N]        : one-hot current owner, zero when none
//   drv_en/drv_en_n : driver enables for bufif1/notif1 and bufif0/notif0 drivers
//   owner_id        : index of owner (0 when none), owner_valid: any grant bit set
//   turn            : high during turnaround cycles
module tristate_bus_sched #(
   parameter int N          = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         drv_en,
   output logic [N-1:0]         drv_en_n,
   output logic [$clog2(N)-1:0] owner_id,
   output logic                 owner_valid,
   output logic                 turn
);
   localparam int W = $clog2(N);
   localparam logic [W-1:0] last_id = W'(N - 1);
   localparam logic [15:0] max_hold = 16'(MAX_HOLD);
   localparam logic [3:0] turn_last = 4'(TURNAROUND - 1);
   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
   state_t state, state_nx;
   logic [W-1:0] rr_ptr, rr_nx, win, owner_nx;
   logic [N-1:0] grant_nx;
   logic [15:0] hold_cnt, hold_nx;
   logic [3:0] turn_cnt, turn_nx;
   logic found, take;
   int j;
   always_comb begin
      found = 1'b0;
      win = '0;
      j = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(rr_ptr) + i) % N;
         if (!found && req[j]) begin
            found = 1'b1;
            win = W'(j);
         end
      end
   end
   // a new owner is taken only from IDLE or on the final turnaround cycle
   assign take = found && (state == IDLE || (state == TURN && turn_cnt == 4'd0));
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      owner_nx = owner_id;
      rr_nx = rr_ptr;
      hold_nx = hold_cnt;
      turn_nx = turn_cnt;
      case (state)
         IDLE: ;
         OWN:
            if (!req[owner_id] || (max_hold != 16'd0 && hold_cnt == max_hold && |(req & ~grant))) begin
               state_nx = TURN;
               grant_nx = '0;
               owner_nx = '0;
               turn_nx = turn_last;
            end else if (max_hold != 16'd0 && hold_cnt != max_hold)
               hold_nx = hold_cnt + 16'd1;
         TURN:
            if (turn_cnt != 4'd0) turn_nx = turn_cnt - 4'd1;
            else if (!found) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (take) begin
         state_nx = OWN;
         grant_nx = N'(1) << win;
         owner_nx = win;
         rr_nx = (win == last_id) ? '0 : win + 1'b1;
         hold_nx = 16'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         hold_cnt <= '0;
         turn_cnt <= '0;
         grant <= '0;
         drv_en <= '0;
         drv_en_n <= '1;
         owner_id <= '0;
         owner_valid <= 1'b0;
         turn <= 1'b0;
      end else begin
         state <= state_nx;
         rr_ptr <= rr_nx;
         hold_cnt <= hold_nx;
         turn_cnt <= turn_nx;
         grant <= grant_nx;
         drv_en <= grant_nx;
         drv_en_n <= ~grant_nx;
         owner_id <= owner_nx;
         owner_valid <= |grant_nx;
         turn <= (state_nx == TURN);
      end
   end
endmodule
